aes_encrypt_iter: RTL and testbench

Iterative AES encryption core: the transmit-side counterpart of the unrolled `AES_Decrypt` datapath, producing the ciphertext that block consumes. It accepts one 128-bit plaintext and key per valid/ready handshake. It expands the key schedule into a local register file at one word per clock, then runs one cipher round per clock. It is parameterized for AES-128/192/256 with the same parameter order as the decrypt block, so one `(KEY_LEN, NR, NK)` triple configures a matched encrypt/decrypt pair.

---
 rtl/aes_pkg.sv | 81 ++++++++
 rtl/aes_enc_round.sv | 52 +++++
 rtl/aes_encrypt_iter.sv | 201 ++++++++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg -- shared AES definitions for the encrypt and decrypt datapaths.
// Contents: legal (KEY_LEN, NR, NK) triples, FSM state enum, GF(2^8)
// helpers (xtime, gf_mul), S-box, SubWord and the Rcon table.
package aes_pkg;

  localparam int AES128_KEY_LEN = 128;
  localparam int AES128_NR      = 10;
  localparam int AES128_NK      = 4;
  localparam int AES192_KEY_LEN = 192;
  localparam int AES192_NR      = 12;
  localparam int AES192_NK      = 6;
  localparam int AES256_KEY_LEN = 256;
  localparam int AES256_NR      = 14;
  localparam int AES256_NK      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } aes_state_e;

  function automatic logic legal_cfg(input int key_len, input int nr, input int nk);
    return (key_len == AES128_KEY_LEN && nr == AES128_NR && nk == AES128_NK) ||
           (key_len == AES192_KEY_LEN && nr == AES192_NR && nk == AES192_NK) ||
           (key_len == AES256_KEY_LEN && nr == AES256_NR && nk == AES256_NK);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box computed as the affine map of the multiplicative inverse; the
  // inverse is x^254 built by repeated squaring (0 maps to 0 naturally).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round -- one combinational AES encryption round.
// Ports:
//   state_i  [127:0] round input state, byte 0 in [127:120], column-major
//   rk_i     [127:0] round key, same byte order
//   final_i          last round: MixColumns is skipped
//   state_o  [127:0] AddRoundKey(MixColumns?(ShiftRows(SubBytes(state_i))))
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] state_o
);

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
    return o;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
      o[103-32*c -: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
    end
    return o;
  endfunction

  logic [127:0] sr;

  assign sr      = shift_rows(sub_bytes(state_i));
  assign state_o = (final_i ? sr : mix_columns(sr)) ^ rk_i;

endmodule

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter -- iterative AES-128/192/256 encryption core.
// Expands the key schedule one word per clock into a local key file, then
// runs one cipher round per clock.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  plaintext+key handshake (ready only in IDLE)
//   in_data  [127:0]     plaintext, byte 0 in [127:120], column-major
//   in_key   [KEY_LEN-1:0] cipher key, w[0] = in_key[KEY_LEN-1 -: 32]
//   out_valid / out_ready ciphertext handshake
//   out_data [127:0]     ciphertext, held until the next block completes
//   busy                 high in every state except IDLE
// Build option: AES_ENC_KEY_CACHE_EN keeps the last expanded key and skips
// key expansion when the next accepted key matches it.
//
// state  | meaning
// IDLE   | waiting for a block, in_ready=1
// KEYEXP | writing one key-schedule word per cycle
// INIT   | initial AddRoundKey with round key 0
// ROUND  | one cipher round per cycle, rounds 1..NR
// DONE   | ciphertext valid, waiting for out_ready
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int KEY_LEN = 128,
  parameter int NR      = 10,
  parameter int NK      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  input  logic [KEY_LEN-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               busy
);

  localparam int NW = 4 * (NR + 1);

  if (!legal_cfg(KEY_LEN, NR, NK)) begin : g_illegal_cfg
    $error("aes_encrypt_iter: unsupported (KEY_LEN, NR, NK) combination");
  end

  aes_state_e   state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] out_q, out_d;
  logic [5:0]   kidx_q, kidx_d;
  logic [2:0]   kmod_q, kmod_d;
  logic [3:0]   rc_q, rc_d;
  logic [3:0]   r_q, r_d;
  logic [31:0]  w_q [NW];

  logic         key_load;
  logic         kf_we;
  logic [31:0]  kf_prev, kf_back, kf_f, kf_wdata;
  logic [5:0]   rk_base;
  logic [127:0] rk_cur;
  logic [127:0] rnd_out;
  logic         cache_hit;

  // Key schedule step for word kidx_q; kmod_q tracks kidx_q mod NK so that
  // the 192-bit case needs no divider.
  always_comb begin
    kf_prev = w_q[kidx_q - 6'd1];
    kf_back = w_q[kidx_q - 6'(NK)];
    if (kmod_q == 3'd0)
      kf_f = sub_word({kf_prev[23:0], kf_prev[31:24]}) ^ {rcon(rc_q), 24'h0};
    else if (NK == 8 && kmod_q == 3'd4)
      kf_f = sub_word(kf_prev);
    else
      kf_f = kf_prev;
    kf_wdata = kf_back ^ kf_f;
  end

  // r_q is 0 during INIT, so the same lookup serves the whitening key.
  assign rk_base = {r_q, 2'b00};
  assign rk_cur  = {w_q[rk_base], w_q[rk_base + 6'd1],
                    w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};

  aes_enc_round u_round (
    .state_i (blk_q),
    .rk_i    (rk_cur),
    .final_i (r_q == 4'(NR)),
    .state_o (rnd_out)
  );

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    out_d    = out_q;
    kidx_d   = kidx_q;
    kmod_d   = kmod_q;
    rc_d     = rc_q;
    r_d      = r_q;
    key_load = 1'b0;
    kf_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d = in_data;
          r_d   = 4'd0;
          if (cache_hit) begin
            state_d = ST_INIT;
          end else begin
            key_load = 1'b1;
            kidx_d   = 6'(NK);
            kmod_d   = 3'd0;
            rc_d     = 4'd1;
            state_d  = ST_KEYEXP;
          end
        end
      end
      ST_KEYEXP: begin
        kf_we  = 1'b1;
        kidx_d = kidx_q + 6'd1;
        kmod_d = (kmod_q == 3'(NK - 1)) ? 3'd0 : kmod_q + 3'd1;
        if (kmod_q == 3'd0) rc_d = rc_q + 4'd1;
        if (kidx_q == 6'(NW - 1)) state_d = ST_INIT;
      end
      ST_INIT: begin
        blk_d   = blk_q ^ rk_cur;
        r_d     = 4'd1;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        blk_d = rnd_out;
        if (r_q == 4'(NR)) begin
          out_d   = rnd_out;
          state_d = ST_DONE;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      out_q   <= '0;
      kidx_q  <= '0;
      kmod_q  <= '0;
      rc_q    <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
      kidx_q  <= kidx_d;
      kmod_q  <= kmod_d;
      rc_q    <= rc_d;
      r_q     <= r_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (key_load) begin
      for (int k = 0; k < NK; k++) w_q[k] <= in_key[KEY_LEN-1-32*k -: 32];
    end else if (kf_we) begin
      w_q[kidx_q] <= kf_wdata;
    end
  end

`ifdef AES_ENC_KEY_CACHE_EN
  logic [KEY_LEN-1:0] ckey_q;
  logic               cvld_q;

  // The key file itself is the cache; only the raw key and a valid bit are
  // added. Valid drops while a new key is being expanded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ckey_q <= '0;
      cvld_q <= 1'b0;
    end else if (key_load) begin
      ckey_q <= in_key;
      cvld_q <= 1'b0;
    end else if (state_q == ST_KEYEXP && kidx_q == 6'(NW - 1)) begin
      cvld_q <= 1'b1;
    end
  end

  assign cache_hit = cvld_q && (in_key == ckey_q);
`else
  assign cache_hit = 1'b0;
`endif

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter -- bench for aes_encrypt_iter with one instance per
// key size, FIPS-197 vectors plus random blocks against a textbook model.
module tb_aes_encrypt_iter;

`ifdef AES_ENC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   out_ready;
  logic [127:0] in_data [3];
  logic [255:0] in_key [3];
  wire  [2:0]   in_ready;
  wire  [2:0]   out_valid;
  wire  [2:0]   busy;
  wire  [127:0] out_data [3];

  int n_chk = 0;
  int n_err = 0;
  int acc_cnt [3] = '{0, 0, 0};
  bit cache_vld [3];
  logic [255:0] cache_key [3];
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KL = 128 + 64 * g;
    aes_encrypt_iter #(.KEY_LEN(KL), .NR(10 + 2 * g), .NK(4 + 2 * g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_key    (in_key[g][255 -: KL]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  // Inputs only change just after rising edges, so the negedge view equals
  // what the next rising edge will accept.
  always @(negedge clk)
    for (int g = 0; g < 3; g++)
      if (rst_n && in_valid[g] && in_ready[g]) acc_cnt[g]++;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                               input int nk);
    int nr;
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] ct;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox_t[s[b]];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++) t[row+4*col] = s[row+4*((col+row)%4)];
      for (int b = 0; b < 16; b++) s[b] = t[b];
      if (r < nr) begin
        for (int col = 0; col < 4; col++) begin
          a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
          s[4*col]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          s[4*col+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) ct[127-8*b -: 8] = s[b];
    return ct;
  endfunction

  function automatic logic [255:0] kmask(input int g);
    logic [255:0] m;
    m = '1;
    return m << (128 - 64 * g);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  task automatic run_block(input int g, input logic [127:0] pt, input logic [255:0] key_in,
                           input logic [127:0] exp_ct, input int hold, input bit noisy,
                           input string tag);
    logic [255:0] key;
    int nk, nr, exp_lat, n, acc0;
    key = key_in & kmask(g);
    nk  = 4 + 2 * g;
    nr  = nk + 6;
    exp_lat = (CACHE_EN && cache_vld[g] && cache_key[g] == key) ? 1 + nr
                                                                : 4 * (nr + 1) - nk + 1 + nr;
    n = 0;
    while (!in_ready[g] && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "/ready"}, 256'(in_ready[g]), 256'd1);
    acc0 = acc_cnt[g];
    in_valid[g] = 1'b1;
    in_data[g]  = pt;
    in_key[g]   = key;
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
    n = 0;
    while (!out_valid[g] && n < 200) begin
      if (noisy) begin
        in_valid[g] = 1'($urandom_range(0, 1));
        in_data[g]  = rnd128();
        in_key[g]   = rnd256();
      end
      @(posedge clk); #1; n++;
    end
    in_valid[g] = 1'b0;
    chk({tag, "/latency"}, 256'(n), 256'(exp_lat));
    chk({tag, "/ct"}, 256'(out_data[g]), 256'(exp_ct));
    chk({tag, "/busy_ready_in_done"}, 256'({busy[g], in_ready[g]}), 256'(2'b10));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, "/hold"}, 256'({out_valid[g], in_ready[g], out_data[g]}), 256'({1'b1, 1'b0, exp_ct}));
    end
    out_ready[g] = 1'b1;
    @(posedge clk); #1;
    out_ready[g] = 1'b0;
    chk({tag, "/release"}, 256'({out_valid[g], in_ready[g], busy[g]}), 256'(3'b010));
    chk({tag, "/ct_kept"}, 256'(out_data[g]), 256'(exp_ct));
    chk({tag, "/handshakes"}, 256'(acc_cnt[g] - acc0), 256'd1);
    cache_vld[g] = 1'b1;
    cache_key[g] = key;
  endtask

  task automatic run_rand(input int g, input int hold, input bit noisy, input bit reuse,
                          input string tag);
    logic [127:0] pt;
    logic [255:0] key;
    pt  = rnd128();
    key = (reuse ? cache_key[g] : rnd256()) & kmask(g);
    run_block(g, pt, key, ref_encrypt(pt, key, 4 + 2 * g), hold, noisy, tag);
  endtask

  task automatic reset_mid_round();
    in_valid[0] = 1'b1;
    in_data[0]  = rnd128();
    in_key[0]   = rnd256() & kmask(0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
    end
    chk("abort/mid_op", 256'({busy[0], out_valid[0]}), 256'(2'b10));
    rst_n = 1'b0;
    #1;
    chk("abort/ctrl", 256'({in_ready, out_valid, busy}), 256'd0);
    for (int g = 0; g < 3; g++) chk("abort/out_data", 256'(out_data[g]), 256'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("abort/no_valid", 256'(out_valid), 256'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) cache_vld[g] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (out_valid[0]) break;
    end
    chk("abort/after_rst", 256'({in_ready, out_valid}), 256'({3'b111, 3'b000}));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int g = 0; g < 3; g++) begin
      in_data[g]   = '0;
      in_key[g]    = '0;
      cache_vld[g] = 1'b0;
      cache_key[g] = '0;
    end
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk("rst/in_ready", 256'(in_ready), 256'd0);
    chk("rst/out_valid", 256'(out_valid), 256'd0);
    chk("rst/busy", 256'(busy), 256'd0);
    for (int g = 0; g < 3; g++) chk("rst/out_data", 256'(out_data[g]), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst/in_ready_after", 256'(in_ready), 256'(3'b111));

    run_block(0, FIPS_PT, K128, CT128, 20, 1'b0, "fips128");
    run_block(1, FIPS_PT, K192, CT192, 0, 1'b0, "fips192");
    run_block(2, FIPS_PT, K256, CT256, 3, 1'b0, "fips256");
    run_block(0, FIPS_PT, K128, CT128, 0, 1'b0, "same_key128");
    run_rand(0, 1, 1'b0, 1'b0, "new_key128");
    run_rand(1, 0, 1'b1, 1'b0, "noisy192");
    run_rand(2, 0, 1'b1, 1'b1, "noisy256");

    reset_mid_round();
    run_block(0, FIPS_PT, K128, CT128, 0, 1'b0, "after_abort128");

    for (int it = 0; it < 9; it++)
      run_rand($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), "rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
